vga_scan_driver: RTL
====================

Name: vga_scan_driver

Overview:
- Downstream consumer of the colour-depth stage: takes the 9-bit `rgbDepth` word (3 bits per channel) and drives the VGA connector.
- Generates horizontal and vertical timing (default 640x480 @ 60 Hz) from the system clock via a pixel-tick divider.
- Emits hsync/vsync and 3-bit R/G/B; colour is forced to zero outside the active region.
- Samples `rgbDepth` once per frame so a depth change never tears mid-frame.

Parameters:
- CLK_DIV, 2: system clocks per pixel tick (>=1).
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, pixels.
- H_SYNC, 96: hsync width, pixels.
- H_BP, 48: horizontal back porch, pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, lines.
- V_SYNC, 2: vsync width, lines.
- V_BP, 33: vertical back porch, lines.
- SYNC_POL, 0: sync active level (0 = active-low).

Ports:
- clock  in  1  system clock; only clock domain.
- reset  in  1  synchronous, active-low reset.
- rgbDepth  in  9  [2:0] red, [5:3] green, [8:6] blue depth.
- hsync  out  1  horizontal sync, polarity per SYNC_POL.
- vsync  out  1  vertical sync, polarity per SYNC_POL.
- red  out  3  red level.
- green  out  3  green level.
- blue  out  3  blue level.
- videoOn  out  1  high while the output pixel is in the active area.
- pixelX  out  10  horizontal counter value of the output pixel.
- pixelY  out  10  vertical counter value of the output pixel.
- frameStart  out  1  one-clock pulse when pixel (0,0) is output.

Behaviour:
- Reset: sampled on the clock edge while reset==0. Clears the following:
  - divCnt=0, hCnt=0, vCnt=0, colorReg=0.
  - Outputs: hsync=vsync=~SYNC_POL, red=green=blue=0, videoOn=0, pixelX=pixelY=0, frameStart=0.
- Reset asserted mid-frame aborts the frame and restarts from these values. There is no partial-line completion.
- Derived totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Divider: divCnt counts 0..CLK_DIV-1 and wraps. tick=1 when divCnt==CLK_DIV-1. With CLK_DIV=1, tick is constantly 1.
- Counters advance only on tick:
  - hCnt increments; when hCnt==H_TOTAL-1 it wraps to 0 and vCnt increments.
  - vCnt wraps to 0 after V_TOTAL-1, on the same tick that hCnt wraps.
- Colour latch: colorReg<=rgbDepth on the tick where hCnt==H_TOTAL-1 and vCnt==V_TOTAL-1 (last pixel of the frame). Not loaded at any other time.
- Output stage: every clock, all outputs are registered from the current hCnt/vCnt/colorReg. Outputs therefore lag the counters by exactly one clock.
  - videoOn = (hCnt<H_ACTIVE)&&(vCnt<V_ACTIVE).
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= hCnt <= H_ACTIVE+H_FP+H_SYNC-1, else ~SYNC_POL.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= vCnt <= V_ACTIVE+V_FP+V_SYNC-1, else ~SYNC_POL.
  - red/green/blue = colorReg[2:0]/[5:3]/[8:6] when videoOn, else 0.
  - pixelX=hCnt, pixelY=vCnt.
  - frameStart=1 only on the clock after the counters transition to (0,0). High for exactly one clock per frame; not asserted for the (0,0) state produced by reset.
- Per-pixel dwell: each output pixel persists CLK_DIV clocks. Sync widths are therefore H_SYNC*CLK_DIV clocks and V_SYNC*H_TOTAL*CLK_DIV clocks.
- rgbDepth may change at any clock. Only the value present on the latch tick is used; intermediate values are ignored.
- First frame after reset shows colour 0, because colorReg is still 0 until the first latch.

Test Plan:
1. Reset values: hold reset=0 for 5 clocks with rgbDepth=9'h1FF.
   - Required: hsync=vsync=1, RGB=0, videoOn=0, frameStart=0.
   - Release reset, run one full frame: RGB stays 0 throughout.
2. Horizontal timing (defaults):
   - hsync low for exactly 192 clocks.
   - Falling-to-falling edge spacing 1600 clocks.
   - videoOn high for 1280 clocks per active line.
   - First hsync fall occurs 1312 clocks plus 1 output-register clock after reset release.
3. Vertical timing:
   - vsync low for exactly 3200 clocks.
   - frameStart pulses spaced exactly 840000 clocks, each 1 clock wide.
   - First frameStart at clock 840001 after reset release.
4. Colour latch:
   - Set rgbDepth=9'b101_011_110 before end of frame 0: frame 1 shows red=110, green=011, blue=101 on every active pixel.
   - Change rgbDepth to 0 at mid frame 1 (pixelY=240): RGB stays unchanged until frame 2.
5. Blanking: during frame 1 with non-zero colour, RGB=0 whenever pixelX>=640 or pixelY>=480, including the cycle pixelX=640.
6. Reset mid-frame:
   - Assert reset at pixelY=100 for 1 clock: all outputs return to reset values next clock, and colorReg is cleared.
   - Timing then repeats test 2/3 numbers from the release point.

Source files
------------

// File: rtl/vga_scan_driver_if.sv
// vga_scan_driver_if
//   Bundles the signals between the colour-depth stage, the VGA scan driver
//   and the connector. Clock and reset are not part of the bundle.
//
//   rgbDepth   [8:0] colour word: [2:0] red, [5:3] green, [8:6] blue
//   hsync, vsync     sync outputs, polarity set by the driver parameter
//   red/green/blue   3-bit colour levels, zero outside the active area
//   videoOn          output pixel lies in the active area
//   pixelX, pixelY   counter position of the output pixel
//   frameStart       one-clock pulse when pixel (0,0) is output
//
//   master: the scan driver (consumes rgbDepth, drives the video signals)
//   slave : the colour source / display side
interface vga_scan_driver_if;
  logic [8:0] rgbDepth;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [2:0] blue;
  logic       videoOn;
  logic [9:0] pixelX;
  logic [9:0] pixelY;
  logic       frameStart;

  modport master (
    input  rgbDepth,
    output hsync, vsync, red, green, blue, videoOn, pixelX, pixelY, frameStart
  );

  modport slave (
    output rgbDepth,
    input  hsync, vsync, red, green, blue, videoOn, pixelX, pixelY, frameStart
  );
endinterface

// File: rtl/vga_scan_driver.sv
// vga_scan_driver
//   Generates VGA horizontal/vertical timing from the system clock through a
//   pixel-tick divider and drives sync plus 3-bit-per-channel colour. The
//   colour word is sampled once per frame, on the last pixel tick, so a depth
//   change never tears an image mid-frame.
//
//   clock   in   system clock
//   reset   in   synchronous, active-low reset
//   vga     master modport of vga_scan_driver_if (rgbDepth in, video out)
//
//   All video outputs are registered from the counters and lag them by one
//   clock.
module vga_scan_driver #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  vga_scan_driver_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT        = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic [8:0]       color_reg;
  logic             frame_wrap;

  logic tick;
  logic h_last;
  logic v_last;
  logic in_active;
  logic in_hsync;
  logic in_vsync;

  // With CLK_DIV=1 div_cnt stays at 0 and DIV_LAST is 0, so tick is always 1.
  assign tick      = (div_cnt == DIV_LAST);
  assign h_last    = (h_cnt == H_LAST);
  assign v_last    = (v_cnt == V_LAST);
  assign in_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign in_hsync  = (h_cnt >= H_SYNC_FIRST) && (h_cnt <= H_SYNC_LAST);
  assign in_vsync  = (v_cnt >= V_SYNC_FIRST) && (v_cnt <= V_SYNC_LAST);

  // Divider, scan counters and the per-frame colour latch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      color_reg  <= '0;
      frame_wrap <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
        if (h_last && v_last) begin
          color_reg <= vga.rgbDepth;
        end
      end
      // Marks the edge where the counters wrap to (0,0); the output stage
      // turns it into frameStart one clock later, alongside pixel (0,0).
      // The (0,0) left by reset never sets it.
      frame_wrap <= tick && h_last && v_last;
    end
  end

  // Registered output stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vga.hsync      <= ~SYNC_POL;
      vga.vsync      <= ~SYNC_POL;
      vga.red        <= 3'd0;
      vga.green      <= 3'd0;
      vga.blue       <= 3'd0;
      vga.videoOn    <= 1'b0;
      vga.pixelX     <= 10'd0;
      vga.pixelY     <= 10'd0;
      vga.frameStart <= 1'b0;
    end else begin
      vga.hsync      <= in_hsync ? SYNC_POL : ~SYNC_POL;
      vga.vsync      <= in_vsync ? SYNC_POL : ~SYNC_POL;
      vga.red        <= in_active ? color_reg[2:0] : 3'd0;
      vga.green      <= in_active ? color_reg[5:3] : 3'd0;
      vga.blue       <= in_active ? color_reg[8:6] : 3'd0;
      vga.videoOn    <= in_active;
      vga.pixelX     <= h_cnt;
      vga.pixelY     <= v_cnt;
      vga.frameStart <= frame_wrap;
    end
  end

endmodule
